cmp_search_ctrl: RTL and testbench

//  Binary-search controller on the driving end of a magnitude comparator
//    (e.g. two_bit_comparator or a wider equivalent).

---
 rtl/cmp_search_ctrl.sv | 155 +++++++++++++++
 tb/tb_cmp_search_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_ctrl.sv
// Binary-search controller driving a magnitude comparator to locate an unknown target (optional check: CMP_ONEHOT_CHECK_EN).
// Latency: done_o pulses 1..WIDTH+1 cycles after the accepted start_i, one comparator evaluation per cycle.
// Backpressure: none; start_i is ignored while busy_o is high and accepted again in the done_o cycle.
module cmp_search_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cmp_eq_i,
  input  logic             cmp_lt_i,
  input  logic             cmp_gt_i,
  output logic [WIDTH-1:0] probe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t state_q, state_d;

  // lo/hi carry one extra bit so lo can pass the top of the range and hi can drop to -1
  logic [WIDTH:0]   lo_q, hi_q, lo_d, hi_d, lo_n, hi_n;
  logic [WIDTH-1:0] probe_d, result_d;
  logic             busy_d, done_d, found_d;
  logic             range_empty;

  localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

  // Midpoint of a non-empty range; the sum is widened so it never overflows
  function automatic logic [WIDTH-1:0] mid_f(input logic [WIDTH:0] lo, input logic [WIDTH:0] hi);
    return WIDTH'(({1'b0, lo} + {1'b0, hi}) >> 1);
  endfunction

`ifdef CMP_ONEHOT_CHECK_EN
  logic       err_q, err_d;
  logic [2:0] cmp_vec;
  logic       cmp_onehot;

  assign cmp_vec    = {cmp_eq_i, cmp_lt_i, cmp_gt_i};
  assign cmp_onehot = (cmp_vec == 3'b100) || (cmp_vec == 3'b010) || (cmp_vec == 3'b001);
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

  // Empty-range test: lo may be 2**WIDTH and hi may be -1, so compare as signed WIDTH+2
  assign range_empty = $signed({1'b0, lo_n}) > $signed({hi_n[WIDTH], hi_n});

  // State and output registers; reset aborts any search without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_o  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      found_o  <= 1'b0;
      result_o <= '0;
`ifdef CMP_ONEHOT_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_o  <= probe_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
      found_o  <= found_d;
      result_o <= result_d;
`ifdef CMP_ONEHOT_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and next-output decode; results hold in IDLE until the next start
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    probe_d  = probe_o;
    busy_d   = busy_o;
    done_d   = 1'b0;
    found_d  = found_o;
    result_d = result_o;
`ifdef CMP_ONEHOT_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          lo_d     = '0;
          hi_d     = HI_INIT;
          probe_d  = mid_f('0, HI_INIT);
          busy_d   = 1'b1;
          found_d  = 1'b0;
          result_d = '0;
`ifdef CMP_ONEHOT_CHECK_EN
          err_d    = 1'b0;
`endif
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
`ifdef CMP_ONEHOT_CHECK_EN
        if (!cmp_onehot) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = '0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else
`endif
        if (cmp_eq_i) begin
          found_d  = 1'b1;
          result_d = probe_o;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          if (cmp_lt_i) begin
            lo_n = {1'b0, probe_o} + (WIDTH+1)'(1);
          end else if (cmp_gt_i) begin
            hi_n = {1'b0, probe_o} - (WIDTH+1)'(1);
          end else begin
            // no flag asserted: narrow downwards, same as gt
            hi_n = {1'b0, probe_o} - (WIDTH+1)'(1);
          end
          lo_d = lo_n;
          hi_d = hi_n;
          if (range_empty) begin
            found_d  = 1'b0;
            result_d = '0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            probe_d = mid_f(lo_n, hi_n);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl with a behavioural comparator on probe_o.
// Table of single searches plus hand sequences for busy-start, done-cycle start and mid-search reset.
// Expectations change with CMP_ONEHOT_CHECK_EN for the illegal comparator encodings.
module tb_cmp_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       cmp_eq, cmp_lt, cmp_gt;
  logic [3:0] probe_o, result_o;
  logic       busy_o, done_o, found_o, err_o;

  logic [3:0] target = 4'd0;
  logic [1:0] mode = 2'd0;   // 0 real compare, 1 force lt, 2 force eq+lt, 3 all zero

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_search_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .cmp_eq_i (cmp_eq),
    .cmp_lt_i (cmp_lt),
    .cmp_gt_i (cmp_gt),
    .probe_o  (probe_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .found_o  (found_o),
    .result_o (result_o),
    .err_o    (err_o)
  );

  // Bench comparator: a = probe_o, b = target, with forced encodings for corner cases
  always_comb begin
    cmp_eq = 1'b0;
    cmp_lt = 1'b0;
    cmp_gt = 1'b0;
    case (mode)
      2'd0: begin
        cmp_eq = (probe_o == target);
        cmp_lt = (probe_o < target);
        cmp_gt = (probe_o > target);
      end
      2'd1: cmp_lt = 1'b1;
      2'd2: begin cmp_eq = 1'b1; cmp_lt = 1'b1; end
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0]  tgt;
    logic [1:0]  md;
    logic [19:0] probes;  // first probe in the low nibble
    int          n;
    logic        found;
    logic [3:0]  res;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One search: start at edge k, collect probes, return evaluation count (0 on timeout)
  task automatic run(input logic [3:0] tgt, input logic [1:0] md, output int n, output logic [31:0] seen);
    @(negedge clk);
    target  = tgt;
    mode    = md;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    n    = 0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (busy_o && i < 8) seen[i*4 +: 4] = probe_o;
      @(posedge clk);
      #1;
      if (done_o) begin
        n = i + 1;
        break;
      end
    end
  endtask

  initial begin
    int          n;
    logic [31:0] seen;
    int          done_cnt;

    vecs[0] = '{4'd7,  2'd0, 20'h00007, 1, 1'b1, 4'd7,  1'b0};
    vecs[1] = '{4'd15, 2'd0, 20'hFEDB7, 5, 1'b1, 4'd15, 1'b0};
    vecs[2] = '{4'd0,  2'd0, 20'h00137, 4, 1'b1, 4'd0,  1'b0};
    vecs[3] = '{4'd9,  2'd0, 20'h009B7, 3, 1'b1, 4'd9,  1'b0};
    vecs[4] = '{4'd5,  2'd0, 20'h00537, 3, 1'b1, 4'd5,  1'b0};
    vecs[5] = '{4'd3,  2'd1, 20'hFEDB7, 5, 1'b0, 4'd0,  1'b0};
    vecs[6] = '{4'd8,  2'd0, 20'h089B7, 4, 1'b1, 4'd8,  1'b0};
`ifdef CMP_ONEHOT_CHECK_EN
    vecs[7] = '{4'd3,  2'd3, 20'h00007, 1, 1'b0, 4'd0,  1'b1};
    vecs[8] = '{4'd3,  2'd2, 20'h00007, 1, 1'b0, 4'd0,  1'b1};
`else
    vecs[7] = '{4'd3,  2'd3, 20'h00137, 4, 1'b0, 4'd0,  1'b0};
    vecs[8] = '{4'd3,  2'd2, 20'h00007, 1, 1'b1, 4'd7,  1'b0};
`endif

    // Reset state
    #12;
    chk("rst_probe",  32'(probe_o),  32'd0);
    chk("rst_busy",   32'(busy_o),   32'd0);
    chk("rst_done",   32'(done_o),   32'd0);
    chk("rst_found",  32'(found_o),  32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_err",    32'(err_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven searches
    for (int v = 0; v < 9; v++) begin
      run(vecs[v].tgt, vecs[v].md, n, seen);
      chk($sformatf("v%0d_latency", v), 32'(n),        32'(vecs[v].n));
      chk($sformatf("v%0d_probes", v),  seen,          32'(vecs[v].probes));
      chk($sformatf("v%0d_found", v),   32'(found_o),  32'(vecs[v].found));
      chk($sformatf("v%0d_result", v),  32'(result_o), 32'(vecs[v].res));
      chk($sformatf("v%0d_err", v),     32'(err_o),    32'(vecs[v].err));
      chk($sformatf("v%0d_busy", v),    32'(busy_o),   32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", v), 32'(done_o),   32'd0);
      chk($sformatf("v%0d_result_hold", v), 32'(result_o), 32'(vecs[v].res));
    end

    // Probe and result hold in IDLE
    run(4'd9, 2'd0, n, seen);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_probe_hold",  32'(probe_o),  32'd9);
    chk("idle_result_hold", 32'(result_o), 32'd9);
    chk("idle_found_hold",  32'(found_o),  32'd1);

    // start_i while busy is ignored
    @(negedge clk);
    target  = 4'd15;
    mode    = 2'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("busy_first_probe", 32'(probe_o), 32'd7);
    @(posedge clk);
    #1;
    chk("busy_second_probe", 32'(probe_o), 32'd11);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("busy_start_ignored", 32'(probe_o), 32'd13);
    chk("busy_still_busy",    32'(busy_o),  32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        n = i + 3;
        break;
      end
    end
    chk("busy_latency", 32'(n),        32'd5);
    chk("busy_result",  32'(result_o), 32'd15);

    // start_i in the done cycle is accepted and clears previous results
    target  = 4'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("donecyc_busy",   32'(busy_o),   32'd1);
    chk("donecyc_probe",  32'(probe_o),  32'd7);
    chk("donecyc_found",  32'(found_o),  32'd0);
    chk("donecyc_result", 32'(result_o), 32'd0);
    @(posedge clk);
    #1;
    chk("donecyc_probe2", 32'(probe_o), 32'd3);

    // Asynchronous reset mid-search
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_probe",  32'(probe_o),  32'd0);
    chk("midrst_busy",   32'(busy_o),   32'd0);
    chk("midrst_done",   32'(done_o),   32'd0);
    chk("midrst_found",  32'(found_o),  32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    chk("midrst_err",    32'(err_o),    32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
